// File: rtl/cc_arb_pkg.sv
// Shared types and default constants for the cache-controller memory read arbiter.
package cc_arb_pkg;

  localparam int CC_ID_W      = 4;
  localparam int CC_ADDR_W    = 32;
  localparam int CC_DATA_W    = 64;
  localparam int CC_TIMEOUT   = 1024;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2
  } state_t;

  // AR payload is carried at the package widths; the top casts to its parameters.
  typedef struct packed {
    logic [CC_ID_W-1:0]   id;
    logic [CC_ADDR_W-1:0] addr;
    logic [3:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
  } ar_pld_t;

endpackage

// File: rtl/cc_rr_arb2.sv
// Two-way round-robin grant, purely combinational: zero latency.
// No backpressure of its own; a request simply stays pending until granted.
module cc_rr_arb2
  import cc_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt,
  output logic       gnt_idx
);

  always_comb begin
    gnt_idx = 1'b0;
    gnt     = 2'b00;
    if (req == 2'b11) begin
      gnt_idx = ~last_grant;
    end else begin
      gnt_idx = req[1];
    end
    if (req != 2'b00) begin
      gnt[gnt_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/cc_mem_rd_arbiter.sv
// Shares one AXI read port between two masters, round-robin, one burst outstanding; watchdog via CC_ARB_TIMEOUT_EN.
// AR registered (1 cycle requester->memory); R is a zero-latency pass-through, 1-cycle bubble between bursts.
// Requester arready only in IDLE; mem_rready follows the granted requester's rready, stray R beats are refused.
module cc_mem_rd_arbiter
  import cc_arb_pkg::*;
#(
  parameter int ID_WIDTH       = CC_ID_W,
  parameter int ADDR_WIDTH     = CC_ADDR_W,
  parameter int DATA_WIDTH     = CC_DATA_W,
  parameter int TIMEOUT_CYCLES = CC_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic [ID_WIDTH-1:0]   s0_arid_i,
  input  logic [ADDR_WIDTH-1:0] s0_araddr_i,
  input  logic [3:0]            s0_arlen_i,
  input  logic [2:0]            s0_arsize_i,
  input  logic [1:0]            s0_arburst_i,
  input  logic                  s0_arvalid_i,
  output logic                  s0_arready_o,
  output logic [ID_WIDTH-1:0]   s0_rid_o,
  output logic [DATA_WIDTH-1:0] s0_rdata_o,
  output logic [1:0]            s0_rresp_o,
  output logic                  s0_rlast_o,
  output logic                  s0_rvalid_o,
  input  logic                  s0_rready_i,

  input  logic [ID_WIDTH-1:0]   s1_arid_i,
  input  logic [ADDR_WIDTH-1:0] s1_araddr_i,
  input  logic [3:0]            s1_arlen_i,
  input  logic [2:0]            s1_arsize_i,
  input  logic [1:0]            s1_arburst_i,
  input  logic                  s1_arvalid_i,
  output logic                  s1_arready_o,
  output logic [ID_WIDTH-1:0]   s1_rid_o,
  output logic [DATA_WIDTH-1:0] s1_rdata_o,
  output logic [1:0]            s1_rresp_o,
  output logic                  s1_rlast_o,
  output logic                  s1_rvalid_o,
  input  logic                  s1_rready_i,

  output logic [ID_WIDTH-1:0]   mem_arid_o,
  output logic [ADDR_WIDTH-1:0] mem_araddr_o,
  output logic [3:0]            mem_arlen_o,
  output logic [2:0]            mem_arsize_o,
  output logic [1:0]            mem_arburst_o,
  output logic                  mem_arvalid_o,
  input  logic                  mem_arready_i,

  input  logic [ID_WIDTH-1:0]   mem_rid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic [1:0]            mem_rresp_i,
  input  logic                  mem_rlast_i,
  input  logic                  mem_rvalid_i,
  output logic                  mem_rready_o,

  output logic                  grant_o,
  output logic                  busy_o,
  output logic                  err_timeout_o
);

  state_t  state_q;
  logic    last_grant_q;
  logic    grant_q;
  ar_pld_t ar_q;
  ar_pld_t ar_win;

  logic [1:0] req;
  logic [1:0] gnt;
  logic       gnt_idx;
  logic       ar_hs;
  logic       r_beat_hs;
  logic       r_last_hs;

  assign req = {s1_arvalid_i, s0_arvalid_i};

  cc_rr_arb2 u_rr (
    .req        (req),
    .last_grant (last_grant_q),
    .gnt        (gnt),
    .gnt_idx    (gnt_idx)
  );

  assign s0_arready_o = (state_q == S_IDLE) & gnt[0];
  assign s1_arready_o = (state_q == S_IDLE) & gnt[1];
  assign ar_hs        = (state_q == S_IDLE) & (req != 2'b00);

  always_comb begin
    ar_win = '0;
    if (gnt_idx) begin
      ar_win.id    = CC_ID_W'(s1_arid_i);
      ar_win.addr  = CC_ADDR_W'(s1_araddr_i);
      ar_win.len   = s1_arlen_i;
      ar_win.size  = s1_arsize_i;
      ar_win.burst = s1_arburst_i;
    end else begin
      ar_win.id    = CC_ID_W'(s0_arid_i);
      ar_win.addr  = CC_ADDR_W'(s0_araddr_i);
      ar_win.len   = s0_arlen_i;
      ar_win.size  = s0_arsize_i;
      ar_win.burst = s0_arburst_i;
    end
  end

  assign mem_arid_o    = ID_WIDTH'(ar_q.id);
  assign mem_araddr_o  = ADDR_WIDTH'(ar_q.addr);
  assign mem_arlen_o   = ar_q.len;
  assign mem_arsize_o  = ar_q.size;
  assign mem_arburst_o = ar_q.burst;
  assign mem_arvalid_o = (state_q == S_AR);

  // R payload fans out to both requesters; only rvalid qualifies who owns it.
  assign mem_rready_o = (state_q == S_R) & (grant_q ? s1_rready_i : s0_rready_i);
  assign s0_rvalid_o  = (state_q == S_R) & ~grant_q & mem_rvalid_i;
  assign s1_rvalid_o  = (state_q == S_R) &  grant_q & mem_rvalid_i;
  assign s0_rid_o     = mem_rid_i;
  assign s1_rid_o     = mem_rid_i;
  assign s0_rdata_o   = mem_rdata_i;
  assign s1_rdata_o   = mem_rdata_i;
  assign s0_rresp_o   = mem_rresp_i;
  assign s1_rresp_o   = mem_rresp_i;
  assign s0_rlast_o   = mem_rlast_i;
  assign s1_rlast_o   = mem_rlast_i;

  assign r_beat_hs = mem_rvalid_i & mem_rready_o;
  assign r_last_hs = r_beat_hs & mem_rlast_i;

  assign grant_o = grant_q;
  assign busy_o  = (state_q != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      ar_q         <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ar_hs) begin
            ar_q    <= ar_win;
            grant_q <= gnt_idx;
            state_q <= S_AR;
          end
        end
        S_AR: begin
          if (mem_arready_i) begin
            state_q <= S_R;
          end
        end
        S_R: begin
          if (r_last_hs) begin
            last_grant_q <= grant_q;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef CC_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wd_cnt_q;
  logic             err_q;

  // Counter saturates at the limit; the error flag only clears on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt_q <= '0;
      err_q    <= 1'b0;
    end else if ((state_q == S_AR) && mem_arready_i) begin
      wd_cnt_q <= '0;
    end else if (state_q == S_R) begin
      if (r_beat_hs) begin
        wd_cnt_q <= '0;
      end else if (wd_cnt_q != CNT_W'(TIMEOUT_CYCLES)) begin
        wd_cnt_q <= wd_cnt_q + CNT_W'(1);
        if ((wd_cnt_q + CNT_W'(1)) == CNT_W'(TIMEOUT_CYCLES)) begin
          err_q <= 1'b1;
        end
      end
    end
  end

  assign err_timeout_o = err_q;
`else
  assign err_timeout_o = 1'b0;
`endif

endmodule

// File: doc/cc_mem_rd_arbiter.md
# cc_mem_rd_arbiter

Two-requester AXI read arbiter that shares the cache controller's single memory AXI read port (AR + R channels) between two read masters, e.g. the miss-fill engine and a prefetch engine. It grants one AR request at a time with round-robin priority and registers it onto the memory AR channel. It then routes the returned R burst to the granted requester until `rlast`, and only then re-arbitrates. It sits between the CC miss path and the `mem_ar*`/`mem_r*` ports of `CC_TOP`.

## Interface
Parameters:
- `ID_WIDTH`, 4, AXI ID width (AR and R).
- `ADDR_WIDTH`, 32, AXI address width.
- `DATA_WIDTH`, 64, R data width.
- `TIMEOUT_CYCLES`, 1024, R-phase watchdog limit (used only with `CC_ARB_TIMEOUT_EN`).

Ports (`s<n>` = `s0` and `s1`, identical sets):
- `clk`  input  1  sole clock, all logic on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `s<n>_arid_i`  input  ID_WIDTH  requester AR ID.
- `s<n>_araddr_i`  input  ADDR_WIDTH  requester AR address.
- `s<n>_arlen_i` / `s<n>_arsize_i` / `s<n>_arburst_i`  input  4 / 3 / 2  requester burst attributes.
- `s<n>_arvalid_i`  input  1  requester AR valid.
- `s<n>_arready_o`  output  1  requester AR ready.
- `s<n>_rid_o` / `s<n>_rdata_o` / `s<n>_rresp_o`  output  ID_WIDTH / DATA_WIDTH / 2  R payload to requester.
- `s<n>_rlast_o` / `s<n>_rvalid_o`  output  1 / 1  R last and valid to requester.
- `s<n>_rready_i`  input  1  requester R ready.
- `mem_arid_o` / `mem_araddr_o` / `mem_arlen_o` / `mem_arsize_o` / `mem_arburst_o`  output  ID_WIDTH / ADDR_WIDTH / 4 / 3 / 2  registered AR to memory.
- `mem_arvalid_o`  output  1  AR valid to memory.
- `mem_arready_i`  input  1  AR ready from memory.
- `mem_rid_i` / `mem_rdata_i` / `mem_rresp_i` / `mem_rlast_i` / `mem_rvalid_i`  input  ID_WIDTH / DATA_WIDTH / 2 / 1 / 1  R from memory.
- `mem_rready_o`  output  1  R ready to memory.
- `grant_o`  output  1  index of the current or last granted requester.
- `busy_o`  output  1  high in AR and R states.
- `err_timeout_o`  output  1  sticky watchdog error.

## Operation
- FSM states: IDLE, AR, R.
- **IDLE**
  - Winner is chosen combinationally from `s0/s1_arvalid_i`.
  - Only one requester valid: it wins.
  - Both valid: the requester not equal to `last_grant` wins.
  - Winner's `arready_o` = 1 in the same cycle; the loser's `arready_o` = 0.
  - On that handshake: AR fields are captured into the output register, `grant_o` = winner, next state AR.
- **AR**
  - `mem_arvalid_o` = 1; fields held stable.
  - Both `s<n>_arready_o` = 0.
  - On `mem_arready_i`: next state R.
- **R**
  - Granted requester: `s_rvalid_o` = `mem_rvalid_i`, R payload passed through, `mem_rready_o` = `s_rready_i`.
  - Other requester: `rvalid_o` = 0.
  - On `mem_rvalid_i & mem_rready_o & mem_rlast_i`: `last_grant` <= `grant_o`, next state IDLE.
- IDLE and AR: `mem_rready_o` = 0. Stray memory R beats are not accepted.
- IDs pass through unmodified. One transaction is outstanding at a time.
- Reset (any state, including mid-burst):
  - Next cycle is IDLE; `last_grant` = 1, so s0 has priority first.
  - All valid and ready outputs are 0; `grant_o` = 0, `busy_o` = 0, `err_timeout_o` = 0.
  - AR payload registers are cleared to 0.

## Timing
- AR handshake on requester → `mem_arvalid_o` high next cycle (1-cycle latency).
- `mem_arready_i` already high: AR state lasts exactly 1 cycle.
- R path is combinational pass-through with zero added latency; no R buffering.
- The cycle after the `rlast` handshake is IDLE. Earliest next requester handshake is that cycle, giving a 1-cycle bubble between bursts.
- `arready_o` depends on `arvalid_i` and never the reverse; `mem_arvalid_o` is never dropped before `mem_arready_i`.

## Configuration
- `CC_ARB_TIMEOUT_EN` defined:
  - A counter clears on entry to R and on every accepted R beat, and increments every other R cycle.
  - When it reaches `TIMEOUT_CYCLES`, `err_timeout_o` is set sticky until `rst`.
  - The FSM is not forced out of R.
- Undefined: no counter is instantiated and `err_timeout_o` is tied to 0.

## Structure
- `cc_arb_pkg` holds:
  - the FSM state enum (`S_IDLE`, `S_AR`, `S_R`);
  - the AR payload struct (id, addr, len, size, burst);
  - the default parameter constants.
- Sub-module `cc_rr_arb2`: combinational 2-way round-robin grant taking `req[1:0]` and `last_grant`, producing a one-hot `gnt` and `gnt_idx`. The top level holds the FSM, AR register, R mux and watchdog.

## Test plan
- Reset, then s0 requests addr 0x0000_1240 with arlen 7 → `s0_arready_o` same cycle; `mem_arvalid_o` next cycle with addr 0x1240; 8 beats delivered to s0 only; IDLE after `rlast`.
- s0 and s1 request simultaneously from reset, repeated → grants alternate s0, s1, s0, s1; `grant_o` matches; no beat reaches the wrong requester.
- `mem_arready_i` held low for 5 cycles → AR payload stable and `mem_arvalid_o` high throughout; no requester `arready` during the stall.
- s1 holds `rready` low for 3 cycles mid-burst → `mem_rready_o` low for the same 3 cycles; all 8 beats arrive in order.
- `rst` pulsed at beat 4 of 8 → next cycle all outputs are at reset values; a new s1 request is serviced normally.
- With `CC_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 16, memory withholds R → `err_timeout_o` rises 16 cycles after R entry and stays high until `rst`.
